syn_update_sequencer: RTL

- Sequencer directly upstream of the synaptic core; drives the core's CTRL_SYNARRAY_CS/WE/ADDR and post-neuron group address during an FF-STDP training pass.
- On START it sweeps every synapse word (pre neuron × post group) as a read-modify-write: read the word, wait for the ffstdp_update results, write the new weights back.
- Also outputs pre/post neuron indices so the neuron memories can present PRE_NEUR_S_CNT / POST_NEUR_S_CNT for the word being processed.

---
 rtl/syn_update_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/syn_update_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// syn_update_sequencer
//
// Walks every synapse word of the synaptic SRAM (pre neuron x post group) as a
// read-modify-write during an FF-STDP training pass: read the word, wait for
// the ffstdp_update results, then write the new weights back to the same word.
// It sits directly upstream of the synaptic core and owns its SRAM control
// while a sweep is running, yielding between words whenever SPI holds the
// SRAM.
//
// Ports:
//   CLK                       system clock, rising edge
//   RST_N                     asynchronous active-low reset
//   START                     one-cycle pulse, begins a sweep (IDLE only)
//   ABORT                     synchronous sweep cancel
//   IS_TRAIN                  START is accepted only while high
//   SPI_GATE_ACTIVITY_sync    high = SPI owns the SRAM, pause between words
//   CTRL_SYNARRAY_CS          SRAM chip select (registered)
//   CTRL_SYNARRAY_WE          SRAM write enable (registered, only with CS)
//   CTRL_SYNARRAY_ADDR        SRAM word address = pre*GROUPS + group
//   CTRL_PRE_NEURON_ADDRESS   pre-neuron index of the current word
//   CTRL_POST_GROUP_ADDRESS   post-neuron group index of the current word
//   BUSY                      high from START acceptance until back in IDLE
//   DONE                      one-cycle pulse after the last write of a sweep
// ---------------------------------------------------------------------------
module syn_update_sequencer #(
    parameter int INPUT_NEURON              = 784,
    parameter int OUTPUT_NEURON             = 256,
    parameter int POST_NEUR_PARALLEL        = 4,
    parameter int PRE_NEUR_ADDR_WIDTH       = 10,
    parameter int POST_NEUR_WORD_ADDR_WIDTH = 8,
    parameter int SYN_ARRAY_ADDR_WIDTH      = 16,
    parameter int UPDATE_LAT                = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 START,
    input  logic                                 ABORT,
    input  logic                                 IS_TRAIN,
    input  logic                                 SPI_GATE_ACTIVITY_sync,
    output logic                                 CTRL_SYNARRAY_CS,
    output logic                                 CTRL_SYNARRAY_WE,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0]      CTRL_SYNARRAY_ADDR,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]       CTRL_PRE_NEURON_ADDRESS,
    output logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] CTRL_POST_GROUP_ADDRESS,
    output logic                                 BUSY,
    output logic                                 DONE
);

    localparam int GROUPS    = OUTPUT_NEURON / POST_NEUR_PARALLEL;
    localparam int WAIT_LAST = (UPDATE_LAT > 0) ? (UPDATE_LAT - 1) : 0;

    localparam logic [PRE_NEUR_ADDR_WIDTH-1:0] PRE_LAST =
        PRE_NEUR_ADDR_WIDTH'(INPUT_NEURON - 1);
    localparam logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] GROUP_LAST =
        POST_NEUR_WORD_ADDR_WIDTH'(GROUPS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [2:0] wait_cnt;
    logic       clear_cnt;
    logic       step_cnt;
    logic       is_last;
    logic       cs_next;
    logic       we_next;
    logic       busy_next;
    logic       done_next;

    assign is_last = (CTRL_PRE_NEURON_ADDRESS == PRE_LAST) &&
                     (CTRL_POST_GROUP_ADDRESS == GROUP_LAST);

    // State register for the sweep FSM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. ABORT beats START in IDLE and beats the SPI gate in
    // ARB. A word that has reached WRITE always finishes its write; ABORT there
    // only suppresses the move to the next word and the DONE pulse. The output
    // flops below are loaded from decodes of next_state so that CS/WE line up
    // with the READ/WRITE state cycles while still coming straight off a flop.
    always_comb begin
        next_state = state;
        clear_cnt  = 1'b0;
        step_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (START && IS_TRAIN && !ABORT) begin
                    next_state = ARB;
                    clear_cnt  = 1'b1;
                end
            end
            ARB: begin
                if (ABORT) begin
                    next_state = IDLE;
                end else if (!SPI_GATE_ACTIVITY_sync) begin
                    next_state = READ;
                end
            end
            READ: begin
                if (ABORT) begin
                    next_state = IDLE;
                end else if (UPDATE_LAT > 0) begin
                    next_state = WAIT;
                end else begin
                    next_state = WRITE;
                end
            end
            WAIT: begin
                if (ABORT) begin
                    next_state = IDLE;
                end else if (wait_cnt == 3'(WAIT_LAST)) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (ABORT || is_last) begin
                    next_state = IDLE;
                end else begin
                    next_state = ARB;
                    step_cnt   = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        cs_next   = (next_state == READ) || (next_state == WRITE);
        we_next   = (next_state == WRITE);
        busy_next = (next_state != IDLE);
        done_next = (state == WRITE) && is_last && !ABORT;
    end

    // Counts the cycles spent in WAIT so the write lands exactly UPDATE_LAT
    // cycles after the read data becomes valid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt <= 3'd0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 3'd1;
        end else begin
            wait_cnt <= 3'd0;
        end
    end

    // Word address plus the (pre, group) pair. The address is its own
    // incrementing counter rather than pre*GROUPS+group, and the pair steps in
    // lockstep with it, so everything only moves when a word's WRITE is left
    // for the next word. In IDLE the last values are simply held.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CTRL_SYNARRAY_ADDR      <= '0;
            CTRL_PRE_NEURON_ADDRESS <= '0;
            CTRL_POST_GROUP_ADDRESS <= '0;
        end else if (clear_cnt) begin
            CTRL_SYNARRAY_ADDR      <= '0;
            CTRL_PRE_NEURON_ADDRESS <= '0;
            CTRL_POST_GROUP_ADDRESS <= '0;
        end else if (step_cnt) begin
            CTRL_SYNARRAY_ADDR <= CTRL_SYNARRAY_ADDR + 1'b1;
            if (CTRL_POST_GROUP_ADDRESS == GROUP_LAST) begin
                CTRL_POST_GROUP_ADDRESS <= '0;
                CTRL_PRE_NEURON_ADDRESS <= CTRL_PRE_NEURON_ADDRESS + 1'b1;
            end else begin
                CTRL_POST_GROUP_ADDRESS <= CTRL_POST_GROUP_ADDRESS + 1'b1;
            end
        end
    end

    // Registered control outputs. Because they are flops on the async reset,
    // pulling RST_N low drops CS/WE/BUSY/DONE immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CTRL_SYNARRAY_CS <= 1'b0;
            CTRL_SYNARRAY_WE <= 1'b0;
            BUSY             <= 1'b0;
            DONE             <= 1'b0;
        end else begin
            CTRL_SYNARRAY_CS <= cs_next;
            CTRL_SYNARRAY_WE <= we_next;
            BUSY             <= busy_next;
            DONE             <= done_next;
        end
    end

endmodule
